// File: rtl/ift_sram_rr_arbiter_if.sv
// Core-side and SRAM-side bus bundle for ift_sram_rr_arbiter, with an IFT taint companion per signal.
// slave = arbiter view, master = requesters/SRAM environment view.
interface ift_sram_rr_arbiter_if #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned Width  = 32,
  parameter int unsigned Aw     = 15
);
  logic [NumReq-1:0]            req_i,   req_i_taint;
  logic [NumReq-1:0]            write_i, write_i_taint;
  logic [NumReq-1:0][Aw-1:0]    addr_i,  addr_i_taint;
  logic [NumReq-1:0][Width-1:0] wdata_i, wdata_i_taint;
  logic [NumReq-1:0][Width-1:0] wmask_i, wmask_i_taint;
  logic [NumReq-1:0]            gnt_o,    gnt_o_taint;
  logic [NumReq-1:0]            rvalid_o, rvalid_o_taint;
  logic [Width-1:0]             rdata_o,  rdata_o_taint;
  logic                         sram_req_o,   sram_req_o_taint;
  logic                         sram_write_o, sram_write_o_taint;
  logic [Aw-1:0]                sram_addr_o,  sram_addr_o_taint;
  logic [Width-1:0]             sram_wdata_o, sram_wdata_o_taint;
  logic [Width-1:0]             sram_wmask_o, sram_wmask_o_taint;
  logic [Width-1:0]             sram_rdata_i, sram_rdata_i_taint;

  modport slave (
    input  req_i, req_i_taint, write_i, write_i_taint, addr_i, addr_i_taint,
           wdata_i, wdata_i_taint, wmask_i, wmask_i_taint, sram_rdata_i, sram_rdata_i_taint,
    output gnt_o, gnt_o_taint, rvalid_o, rvalid_o_taint, rdata_o, rdata_o_taint,
           sram_req_o, sram_req_o_taint, sram_write_o, sram_write_o_taint,
           sram_addr_o, sram_addr_o_taint, sram_wdata_o, sram_wdata_o_taint,
           sram_wmask_o, sram_wmask_o_taint
  );

  modport master (
    output req_i, req_i_taint, write_i, write_i_taint, addr_i, addr_i_taint,
           wdata_i, wdata_i_taint, wmask_i, wmask_i_taint, sram_rdata_i, sram_rdata_i_taint,
    input  gnt_o, gnt_o_taint, rvalid_o, rvalid_o_taint, rdata_o, rdata_o_taint,
           sram_req_o, sram_req_o_taint, sram_write_o, sram_write_o_taint,
           sram_addr_o, sram_addr_o_taint, sram_wdata_o, sram_wdata_o_taint,
           sram_wmask_o, sram_wmask_o_taint
  );
endinterface

// File: rtl/ift_sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port tainted SRAM (1-cycle read latency) among NumReq requesters.
// Optional IFT_SRAM_ARB_CONSERVATIVE_GNT_EN: any tainted request taints all grants; sticky pointer taint.
module ift_sram_rr_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned Width     = 32,
  parameter int unsigned Depth     = 1 << 15,
  parameter int unsigned NumTaints = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  ift_sram_rr_arbiter_if.slave bus
);
  localparam int unsigned   Aw      = $clog2(Depth);
  localparam int unsigned   PtrW    = $clog2(NumReq);
  localparam logic [PtrW:0] NumReqW = (PtrW + 1)'(NumReq);

  if (NumReq < 2 || NumTaints != 1) begin : g_param_check
    $error("ift_sram_rr_arbiter: NumReq must be >= 2 and NumTaints must be 1");
  end

  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   resp_owner_q, resp_owner_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_taint_q, resp_taint_d;
  logic              found, ahead_taint, rd_like;
  logic [PtrW-1:0]   winner, idx;
  logic [PtrW:0]     pos, pos_n;
  logic [NumReq-1:0] gnt, gnt_taint, rvalid, rvalid_taint;
  logic [Aw-1:0]     addr_mux, addr_taint_mux;
  logic [Width-1:0]  wdata_mux, wdata_taint_mux, wmask_mux, wmask_taint_mux;
  logic              write_mux, write_taint_mux, req_taint;

`ifdef IFT_SRAM_ARB_CONSERVATIVE_GNT_EN
  logic ptr_taint_q, ptr_taint_d;
`endif

  always_comb begin
    found       = 1'b0;
    ahead_taint = 1'b0;
    winner      = '0;
    idx         = '0;
    pos         = '0;
    // Requesters searched before the winner had req=0; their taint could have flipped the outcome.
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = {1'b0, rr_ptr_q} + (PtrW + 1)'(k);
      if (pos >= NumReqW) pos = pos - NumReqW;
      idx = pos[PtrW-1:0];
      if (!found) begin
        if (bus.req_i[idx]) begin
          found  = 1'b1;
          winner = idx;
        end else begin
          ahead_taint = ahead_taint | bus.req_i_taint[idx];
        end
      end
    end

    pos_n = {1'b0, winner} + (PtrW + 1)'(1);
    if (pos_n >= NumReqW) pos_n = '0;
    rr_ptr_d = found ? pos_n[PtrW-1:0] : rr_ptr_q;

    gnt = '0;
    if (found) gnt[winner] = 1'b1;

`ifdef IFT_SRAM_ARB_CONSERVATIVE_GNT_EN
    ptr_taint_d = ptr_taint_q | (found & (|bus.req_i_taint));
    gnt_taint   = (ptr_taint_q | (|bus.req_i_taint)) ? '1 : '0;
`else
    gnt_taint   = bus.req_i_taint;
`endif

    write_mux       = 1'b0;
    write_taint_mux = 1'b0;
    addr_mux        = '0;
    addr_taint_mux  = '0;
    wdata_mux       = '0;
    wdata_taint_mux = '0;
    wmask_mux       = '0;
    wmask_taint_mux = '0;
    req_taint       = ahead_taint;
    if (found) begin
      write_mux       = bus.write_i[winner];
      write_taint_mux = bus.write_i_taint[winner];
      addr_mux        = bus.addr_i[winner];
      addr_taint_mux  = bus.addr_i_taint[winner];
      wdata_mux       = bus.wdata_i[winner];
      wdata_taint_mux = bus.wdata_i_taint[winner];
      wmask_mux       = bus.wmask_i[winner];
      wmask_taint_mux = bus.wmask_i_taint[winner];
      req_taint       = ahead_taint | bus.req_i_taint[winner];
    end

    // A tainted write flag may really have been a read, so its response slot carries taint.
    rd_like      = found & (~write_mux | write_taint_mux);
    resp_valid_d = found & ~write_mux;
    resp_owner_d = rd_like ? winner : resp_owner_q;
    resp_taint_d = rd_like & (gnt_taint[winner] | write_taint_mux);

    rvalid       = '0;
    rvalid_taint = '0;
    if (resp_valid_q) rvalid[resp_owner_q]       = 1'b1;
    if (resp_taint_q) rvalid_taint[resp_owner_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      resp_owner_q <= '0;
      resp_valid_q <= 1'b0;
      resp_taint_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_owner_q <= resp_owner_d;
      resp_valid_q <= resp_valid_d;
      resp_taint_q <= resp_taint_d;
    end
  end

`ifdef IFT_SRAM_ARB_CONSERVATIVE_GNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_taint_q <= 1'b0;
    else       ptr_taint_q <= ptr_taint_d;
  end
`endif

  assign bus.gnt_o              = gnt;
  assign bus.gnt_o_taint        = gnt_taint;
  assign bus.rvalid_o           = rvalid;
  assign bus.rvalid_o_taint     = rvalid_taint;
  assign bus.rdata_o            = bus.sram_rdata_i;
  assign bus.rdata_o_taint      = bus.sram_rdata_i_taint | {Width{resp_taint_q}};
  assign bus.sram_req_o         = found;
  assign bus.sram_req_o_taint   = req_taint;
  assign bus.sram_write_o       = write_mux;
  assign bus.sram_write_o_taint = write_taint_mux;
  assign bus.sram_addr_o        = addr_mux;
  assign bus.sram_addr_o_taint  = addr_taint_mux;
  assign bus.sram_wdata_o       = wdata_mux;
  assign bus.sram_wdata_o_taint = wdata_taint_mux;
  assign bus.sram_wmask_o       = wmask_mux;
  assign bus.sram_wmask_o_taint = wmask_taint_mux;
endmodule

// File: tb/tb_ift_sram_rr_arbiter.sv
// Directed bench for ift_sram_rr_arbiter (NumReq=2) with a small behavioural SRAM behind it.
module tb_ift_sram_rr_arbiter;
`ifdef IFT_SRAM_ARB_CONSERVATIVE_GNT_EN
  localparam bit Cons = 1'b1;
`else
  localparam bit Cons = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [31:0] mem [256];

  ift_sram_rr_arbiter_if #(.NumReq(2), .Width(32), .Aw(15)) bus ();

  ift_sram_rr_arbiter #(.NumReq(2), .Width(32), .Depth(1 << 15), .NumTaints(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_req_o) begin
      if (bus.sram_write_o)
        mem[bus.sram_addr_o[7:0]] <= (mem[bus.sram_addr_o[7:0]] & ~bus.sram_wmask_o)
                                     | (bus.sram_wdata_o & bus.sram_wmask_o);
      else
        bus.sram_rdata_i <= mem[bus.sram_addr_o[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.req_i = '0;   bus.req_i_taint = '0;
    bus.write_i = '0; bus.write_i_taint = '0;
    bus.addr_i = '0;  bus.addr_i_taint = '0;
    bus.wdata_i = '0; bus.wdata_i_taint = '0;
    bus.wmask_i = '0; bus.wmask_i_taint = '0;
    bus.sram_rdata_i_taint = '0;
  endtask

  task automatic rq(input int i, input logic wr, input logic [14:0] a,
                    input logic [31:0] d, input logic [31:0] m);
    bus.req_i[i]   = 1'b1;
    bus.write_i[i] = wr;
    bus.addr_i[i]  = a;
    bus.wdata_i[i] = d;
    bus.wmask_i[i] = m;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'h1111_0010;
    mem[8'h20] = 32'h2222_0020;
    bus.sram_rdata_i = '0;
    rst = 1'b1;
    clr();
    repeat (2) step();
    rst = 1'b0;
    #2;
    check("rst_rvalid", bus.rvalid_o, 2'b00);
    check("rst_rvalid_taint", bus.rvalid_o_taint, 2'b00);
    check("rst_gnt", bus.gnt_o, 2'b00);
    check("rst_sram_req", bus.sram_req_o, 1'b0);
    check("rst_rdata_taint", bus.rdata_o_taint, 32'h0);

    // Both requesters read every cycle: grants alternate from pointer 0.
    rq(0, 1'b0, 15'h10, 32'h0, 32'h0);
    rq(1, 1'b0, 15'h20, 32'h0, 32'h0);
    #2;
    check("t1_gnt_a", bus.gnt_o, 2'b01);
    check("t1_addr_a", bus.sram_addr_o, 15'h10);
    check("t1_req_a", bus.sram_req_o, 1'b1);
    step(); #2;
    check("t1_gnt_b", bus.gnt_o, 2'b10);
    check("t1_addr_b", bus.sram_addr_o, 15'h20);
    check("t1_rvalid_b", bus.rvalid_o, 2'b01);
    check("t1_rdata_b", bus.rdata_o, 32'h1111_0010);
    step(); #2;
    check("t1_gnt_c", bus.gnt_o, 2'b01);
    check("t1_rvalid_c", bus.rvalid_o, 2'b10);
    check("t1_rdata_c", bus.rdata_o, 32'h2222_0020);
    step(); clr(); #2;
    check("t1_gnt_idle", bus.gnt_o, 2'b00);
    check("t1_rvalid_d", bus.rvalid_o, 2'b01);
    check("t1_rdata_d", bus.rdata_o, 32'h1111_0010);
    step(); #2;
    check("t1_rvalid_e", bus.rvalid_o, 2'b00);

    // Write then read-back through the other requester (pointer is 1 here).
    rq(0, 1'b1, 15'h4, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    #2;
    check("t2_gnt_w", bus.gnt_o, 2'b01);
    check("t2_write", bus.sram_write_o, 1'b1);
    check("t2_wdata", bus.sram_wdata_o, 32'hDEAD_BEEF);
    check("t2_wmask", bus.sram_wmask_o, 32'hFFFF_FFFF);
    step(); clr(); rq(1, 1'b0, 15'h4, 32'h0, 32'h0); #2;
    check("t2_gnt_r", bus.gnt_o, 2'b10);
    check("t2_no_wr_rvalid", bus.rvalid_o, 2'b00);
    step(); clr(); #2;
    check("t2_rvalid", bus.rvalid_o, 2'b10);
    check("t2_rdata", bus.rdata_o, 32'hDEAD_BEEF);

    // Pointer 0: req0 alone -> ptr 1; req1 alone wraps to 0; idle holds.
    step(); rq(0, 1'b0, 15'h8, 32'h0, 32'h0); #2;
    check("t3_gnt0", bus.gnt_o, 2'b01);
    step(); clr(); rq(1, 1'b0, 15'h8, 32'h0, 32'h0); #2;
    check("t3_gnt1", bus.gnt_o, 2'b10);
    step(); clr(); #2;
    check("t3_idle_req", bus.sram_req_o, 1'b0);
    check("t3_idle_gnt", bus.gnt_o, 2'b00);
    check("t3_idle_addr", bus.sram_addr_o, 15'h0);
    step();
    step(); rq(0, 1'b0, 15'h10, 32'h0, 32'h0); rq(1, 1'b0, 15'h20, 32'h0, 32'h0); #2;
    check("t3_wrap_ptr0", bus.gnt_o, 2'b01);
    step(); clr(); #2;
    step(); rq(0, 1'b0, 15'h10, 32'h0, 32'h0); rq(1, 1'b0, 15'h20, 32'h0, 32'h0); #2;
    check("t3_hold_ptr1", bus.gnt_o, 2'b10);

    // Pointer 0: tainted address on a clean read.
    step(); clr(); rq(0, 1'b0, 15'h30, 32'h0, 32'h0); bus.addr_i_taint[0] = 15'h1; #2;
    check("t4_addr_taint", bus.sram_addr_o_taint, 15'h1);
    check("t4_req_taint", bus.sram_req_o_taint, 1'b0);
    check("t4_gnt_taint", bus.gnt_o_taint, 2'b00);
    step(); clr(); bus.sram_rdata_i_taint = 32'h0000_FF00; #2;
    check("t4_rvalid", bus.rvalid_o, 2'b01);
    check("t4_rdata_taint", bus.rdata_o_taint, 32'h0000_FF00);
    check("t4_rvalid_taint", bus.rvalid_o_taint, 2'b00);

    // Pointer 1: tainted idle req1 is searched ahead of winner 0.
    step(); clr(); rq(0, 1'b0, 15'h10, 32'h0, 32'h0); bus.req_i_taint[1] = 1'b1; #2;
    check("t5_gnt", bus.gnt_o, 2'b01);
    check("t5_req_taint_ahead", bus.sram_req_o_taint, 1'b1);
    check("t5_gnt_taint", bus.gnt_o_taint, Cons ? 2'b11 : 2'b10);
    step(); clr(); #2;
    check("t5_rvalid_taint", bus.rvalid_o_taint, Cons ? 2'b01 : 2'b00);
    check("t5_rdata_taint", bus.rdata_o_taint, Cons ? 32'hFFFF_FFFF : 32'h0);
    check("t5_gnt_taint_sticky", bus.gnt_o_taint, Cons ? 2'b11 : 2'b00);
    rq(1, 1'b0, 15'h8, 32'h0, 32'h0); #2;
    check("t5_gnt1", bus.gnt_o, 2'b10);
    step(); clr(); rq(0, 1'b0, 15'h10, 32'h0, 32'h0); bus.req_i_taint[1] = 1'b1; #2;
    check("t5_req_taint_behind", bus.sram_req_o_taint, 1'b0);
    step(); clr(); rq(0, 1'b1, 15'h40, 32'h5, 32'hFFFF_FFFF); bus.write_i_taint[0] = 1'b1; #2;
    check("t5_wr_gnt", bus.gnt_o, 2'b01);
    check("t5_wr_taint", bus.sram_write_o_taint, 1'b1);
    step(); clr(); #2;
    check("t5_wr_rvalid", bus.rvalid_o, 2'b00);
    check("t5_wr_rvalid_taint", bus.rvalid_o_taint, 2'b01);
    check("t5_wr_rdata_taint", bus.rdata_o_taint, 32'hFFFF_FFFF);

    // Pointer 1: read grant, then reset in the following cycle.
    rq(0, 1'b0, 15'h20, 32'h0, 32'h0); #2;
    check("t6_gnt", bus.gnt_o, 2'b01);
    step(); clr(); rst = 1'b1;
    step(); rst = 1'b0; #2;
    check("t6_rvalid", bus.rvalid_o, 2'b00);
    check("t6_rvalid_taint", bus.rvalid_o_taint, 2'b00);
    check("t6_rdata_taint", bus.rdata_o_taint, 32'h0);
    check("t6_gnt_taint", bus.gnt_o_taint, 2'b00);
    rq(0, 1'b0, 15'h10, 32'h0, 32'h0); rq(1, 1'b0, 15'h20, 32'h0, 32'h0); #2;
    check("t6_ptr0", bus.gnt_o, 2'b01);
    check("t6_req_taint", bus.sram_req_o_taint, 1'b0);
    step(); clr();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
